// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared encodings for the LSB/fetch memory responder
package mem_responder_pkg;
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE_D, DONE_I} state_t;
  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;
  localparam logic [31:0] IO_LO_DEF = 32'h0003_0000;
  localparam logic [31:0] IO_HI_DEF = 32'h0003_0007;
  // 011 and 11x fall through to a full word
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == 2'd0 ? 3'd1 : len == 2'd1 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: LSB request, fetch and byte-wide RAM/IO bus signals
interface mem_responder_if;
  logic        mem_valid, mem_wr, mem_ready;
  logic [2:0]  mem_len;
  logic [31:0] mem_addr, mem_value, mem_result;
  logic        if_valid, if_ready;
  logic [31:0] if_addr, if_data;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr, io_buffer_full;
  modport slave (
    input  mem_valid, mem_wr, mem_len, mem_addr, mem_value, if_valid, if_addr, ram_din, io_buffer_full,
    output mem_ready, mem_result, if_ready, if_data, ram_dout, ram_a, ram_wr
  );
  modport master (
    output mem_valid, mem_wr, mem_len, mem_addr, mem_value, if_valid, if_addr, ram_din, io_buffer_full,
    input  mem_ready, mem_result, if_ready, if_data, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_responder_extend.sv
// mem_extend: sign/zero extension of raw load bytes by funct3
module mem_extend
  import mem_responder_pkg::*;
(
  input  logic [2:0]  len,
  input  logic [31:0] raw,
  output logic [31:0] ext
);
  assign ext = len == LEN_B  ? {{24{raw[7]}}, raw[7:0]} :
               len == LEN_H  ? {{16{raw[15]}}, raw[15:0]} :
               len == LEN_BU ? {24'd0, raw[7:0]} :
               len == LEN_HU ? {16'd0, raw[15:0]} : raw;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: serialises LSB loads/stores and instruction fetches onto a byte-wide RAM/IO bus
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [31:0] IO_ADDR_LO = IO_LO_DEF,
  parameter logic [31:0] IO_ADDR_HI = IO_HI_DEF
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic rob_clear,
  mem_responder_if.slave bus
);
  state_t state, state_n;
  logic [31:0] addr_r, value_r, data_r, ext, byte_a;
  logic [2:0] len_r, ai, ci, n;
  logic wr_r, fetch_r, pend, rdy_q, accept, last_cap, io_hold, wr_ok;
  assign n = len_bytes(len_r[1:0]);
  assign accept = state inside {IDLE, DONE_D, DONE_I} && !rob_clear && (bus.mem_valid || bus.if_valid);
  assign byte_a = addr_r + {29'd0, ai};
  assign io_hold = byte_a >= IO_ADDR_LO && byte_a <= IO_ADDR_HI && bus.io_buffer_full;
  assign wr_ok = state == WRITE && !io_hold;
  // ai issues addresses, ci counts captured bytes; rdy_q tells whether ram_din belongs to the last issue
  assign last_cap = rdy_q && pend && ci + 3'd1 == n;
  always_comb begin
    state_n = state;
    case (state)
      READ:    state_n = rob_clear ? IDLE : last_cap ? (fetch_r ? DONE_I : DONE_D) : READ;
      WRITE:   state_n = wr_ok && ai == n - 3'd1 ? DONE_D : WRITE;
      default: state_n = accept ? (bus.mem_valid && bus.mem_wr ? WRITE : READ) : IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      addr_r <= '0;
      value_r <= '0;
      data_r <= '0;
      len_r <= '0;
      ai <= '0;
      ci <= '0;
      wr_r <= 1'b0;
      fetch_r <= 1'b0;
      pend <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= rdy_in;
      if (rdy_in) begin
        state <= state_n;
        if (accept) begin
          addr_r <= bus.mem_valid ? bus.mem_addr : bus.if_addr;
          len_r <= bus.mem_valid ? bus.mem_len : LEN_W;
          value_r <= bus.mem_value;
          wr_r <= bus.mem_valid && bus.mem_wr;
          fetch_r <= !bus.mem_valid;
          data_r <= '0;
          ai <= '0;
          ci <= '0;
          pend <= 1'b0;
        end else if (state == READ && !rdy_q) begin
          // first edge after a pause: the in-flight byte was lost, re-issue from the capture point
          ai <= ci;
          pend <= 1'b0;
        end else if (state == READ) begin
          if (pend) begin
            data_r[{ci[1:0], 3'd0} +: 8] <= bus.ram_din;
            ci <= ci + 3'd1;
          end
          pend <= ai < n;
          if (ai < n) ai <= ai + 3'd1;
        end else if (wr_ok) begin
          ai <= ai + 3'd1;
        end
      end
    end
  end
  mem_extend u_ext (.len(len_r), .raw(data_r), .ext(ext));
  assign bus.ram_a = state inside {READ, WRITE} ? byte_a : '0;
  assign bus.ram_dout = state == WRITE ? value_r[{ai[1:0], 3'd0} +: 8] : '0;
  assign bus.ram_wr = wr_ok && rdy_in;
  // committed stores still report completion during a flush
  assign bus.mem_ready = state == DONE_D && rdy_in && (wr_r || !rob_clear);
  assign bus.mem_result = bus.mem_ready && !wr_r ? ext : '0;
  assign bus.if_ready = state == DONE_I && rdy_in && !rob_clear;
  assign bus.if_data = bus.if_ready ? data_r : '0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
module tb_mem_responder;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, rob_clear;
  int checks = 0;
  int failures = 0;
  logic [7:0] ram_m [0:4095];
  logic [31:0] wa [$];
  logic [7:0] wd [$];
  mem_responder_if bus();
  mem_responder dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear), .bus(bus));
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    bus.ram_din <= ram_m[bus.ram_a[11:0]];
    if (bus.ram_wr) begin
      wa.push_back(bus.ram_a);
      wd.push_back(bus.ram_dout);
    end
  end
  task automatic cyc;
    @(posedge clk_in);
    #2;
  endtask
  task automatic req(input logic wr, input logic [2:0] len, input logic [31:0] addr, input logic [31:0] val);
    bus.mem_valid = 1'b1;
    bus.mem_wr = wr;
    bus.mem_len = len;
    bus.mem_addr = addr;
    bus.mem_value = val;
    cyc;
    bus.mem_valid = 1'b0;
  endtask
  task automatic wait_mem(output int lat, output logic [31:0] res);
    lat = -1;
    res = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (bus.mem_ready) begin
        lat = k;
        res = bus.mem_result;
        break;
      end
      cyc;
    end
  endtask
  task automatic test_reset;
    cyc;
    cyc;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got=%b want=0", bus.mem_ready); end
    checks++; if (bus.mem_result !== 32'h0) begin failures++; $display("FAIL reset_mem_result got=%h want=0", bus.mem_result); end
    checks++; if (bus.if_ready !== 1'b0 || bus.if_data !== 32'h0) begin failures++; $display("FAIL reset_if got=%b/%h want=0/0", bus.if_ready, bus.if_data); end
    checks++; if (bus.ram_a !== 32'h0 || bus.ram_dout !== 8'h0 || bus.ram_wr !== 1'b0) begin failures++; $display("FAIL reset_ram got=%h/%h/%b want=0/0/0", bus.ram_a, bus.ram_dout, bus.ram_wr); end
    rst_in = 1'b0;
    cyc;
  endtask
  task automatic test_lw;
    req(1'b0, 3'b010, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.ram_a !== 32'h100 + k || bus.ram_wr !== 1'b0) begin failures++; $display("FAIL lw_addr%0d got=%h/%b want=%h/0", k, bus.ram_a, bus.ram_wr, 32'h100 + k); end
      checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL lw_early%0d got=%b want=0", k, bus.mem_ready); end
      cyc;
    end
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL lw_t5 got=%b want=0", bus.mem_ready); end
    cyc;
    checks++; if (bus.mem_ready !== 1'b1 || bus.mem_result !== 32'h12345678) begin failures++; $display("FAIL lw_t6 got=%b/%h want=1/12345678", bus.mem_ready, bus.mem_result); end
    cyc;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL lw_t7 got=%b want=0", bus.mem_ready); end
  endtask
  task automatic test_loads;
    logic [2:0] lv [8];
    logic [31:0] av [8];
    logic [31:0] ev [8];
    int tv [8];
    int lat;
    logic [31:0] res;
    lv = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b111, 3'b010, 3'b010};
    av = '{32'h200, 32'h200, 32'h210, 32'h210, 32'h100, 32'h100, 32'h101, 32'hFFFF_FFFE};
    ev = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h1234_5678, 32'h1234_5678, 32'h9A12_3456, 32'h4433_2211};
    tv = '{3, 3, 4, 4, 6, 6, 6, 6};
    for (int i = 0; i < 8; i++) begin
      req(1'b0, lv[i], av[i], 32'h0);
      wait_mem(lat, res);
      checks++; if (res !== ev[i]) begin failures++; $display("FAIL load%0d_data got=%h want=%h", i, res, ev[i]); end
      checks++; if (lat !== tv[i]) begin failures++; $display("FAIL load%0d_latency got=%0d want=%0d", i, lat, tv[i]); end
      cyc;
    end
  endtask
  task automatic test_store_io;
    wa.delete();
    wd.delete();
    bus.io_buffer_full = 1'b1;
    req(1'b1, 3'b001, 32'h3_0000, 32'h0000_BEEF);
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'h3_0000) begin failures++; $display("FAIL io_full%0d got=%b/%h want=0/00030000", k, bus.ram_wr, bus.ram_a); end
      if (k < 2) cyc;
    end
    bus.io_buffer_full = 1'b0;
    #1;
    checks++; if (bus.ram_wr !== 1'b1 || bus.ram_dout !== 8'hEF || bus.ram_a !== 32'h3_0000) begin failures++; $display("FAIL io_b0 got=%b/%h/%h want=1/ef/00030000", bus.ram_wr, bus.ram_dout, bus.ram_a); end
    cyc;
    checks++; if (bus.ram_wr !== 1'b1 || bus.ram_dout !== 8'hBE || bus.ram_a !== 32'h3_0001) begin failures++; $display("FAIL io_b1 got=%b/%h/%h want=1/be/00030001", bus.ram_wr, bus.ram_dout, bus.ram_a); end
    cyc;
    checks++; if (bus.mem_ready !== 1'b1 || bus.mem_result !== 32'h0 || bus.ram_wr !== 1'b0) begin failures++; $display("FAIL io_done got=%b/%h/%b want=1/0/0", bus.mem_ready, bus.mem_result, bus.ram_wr); end
    cyc;
    checks++; if (wa.size() !== 2) begin failures++; $display("FAIL io_wcount got=%0d want=2", wa.size()); end
    else begin
      checks++; if ({wd[1], wd[0]} !== 16'hBEEF) begin failures++; $display("FAIL io_wdata got=%h want=beef", {wd[1], wd[0]}); end
    end
  endtask
  task automatic test_priority;
    int lat;
    logic [31:0] res;
    logic early;
    bus.mem_valid = 1'b1; bus.mem_wr = 1'b0; bus.mem_len = 3'b010; bus.mem_addr = 32'h100;
    bus.if_valid = 1'b1; bus.if_addr = 32'h400;
    cyc;
    lat = -1; early = 1'b0; res = 'x;
    for (int k = 1; k <= 40; k++) begin
      early |= bus.if_ready;
      if (bus.mem_ready) begin lat = k; res = bus.mem_result; break; end
      cyc;
    end
    checks++; if (lat !== 6 || res !== 32'h12345678 || early !== 1'b0) begin failures++; $display("FAIL prio_first got=%0d/%h/%b want=6/12345678/0", lat, res, early); end
    bus.mem_len = 3'b000; bus.mem_addr = 32'h200;
    cyc;
    lat = -1; early = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      early |= bus.if_ready;
      if (bus.mem_ready) begin lat = k; res = bus.mem_result; break; end
      cyc;
    end
    checks++; if (lat !== 3 || res !== 32'hFFFF_FF80 || early !== 1'b0) begin failures++; $display("FAIL prio_second got=%0d/%h/%b want=3/ffffff80/0", lat, res, early); end
    bus.mem_valid = 1'b0;
    cyc;
    lat = -1; early = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      early |= bus.mem_ready;
      if (bus.if_ready) begin lat = k; res = bus.if_data; break; end
      cyc;
    end
    checks++; if (lat !== 6 || res !== 32'hDEAD_BEEF || early !== 1'b0) begin failures++; $display("FAIL prio_fetch got=%0d/%h/%b want=6/deadbeef/0", lat, res, early); end
    bus.if_valid = 1'b0;
    cyc;
  endtask
  task automatic test_rob_clear_load;
    logic seen;
    req(1'b0, 3'b010, 32'h100, 32'h0);
    cyc;
    rob_clear = 1'b1;
    cyc;
    rob_clear = 1'b0;
    checks++; if (bus.ram_a !== 32'h0) begin failures++; $display("FAIL clr_idle got=%h want=0", bus.ram_a); end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin seen |= bus.mem_ready; cyc; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL clr_nopulse got=%b want=0", seen); end
    req(1'b0, 3'b000, 32'h200, 32'h0);
    cyc;
    cyc;
    rob_clear = 1'b1;
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL clr_done got=%b want=0", bus.mem_ready); end
    cyc;
    rob_clear = 1'b0;
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL clr_after got=%b want=0", bus.mem_ready); end
    cyc;
  endtask
  task automatic test_rob_clear_store;
    int lat;
    logic [31:0] res;
    wa.delete();
    wd.delete();
    req(1'b1, 3'b010, 32'h500, 32'hCAFE_F00D);
    cyc;
    rob_clear = 1'b1;
    cyc;
    rob_clear = 1'b0;
    wait_mem(lat, res);
    checks++; if (lat !== 3 || res !== 32'h0) begin failures++; $display("FAIL clrst_pulse got=%0d/%h want=3/0", lat, res); end
    cyc;
    checks++; if (wa.size() !== 4) begin failures++; $display("FAIL clrst_wcount got=%0d want=4", wa.size()); end
    else begin
      checks++; if ({wd[3], wd[2], wd[1], wd[0]} !== 32'hCAFE_F00D || wa[0] !== 32'h500 || wa[3] !== 32'h503) begin failures++; $display("FAIL clrst_wdata got=%h@%h..%h want=cafef00d@500..503", {wd[3], wd[2], wd[1], wd[0]}, wa[0], wa[3]); end
    end
  endtask
  task automatic test_rdy_pause;
    int lat;
    logic [31:0] res;
    req(1'b0, 3'b010, 32'h100, 32'h0);
    cyc;
    rdy_in = 1'b0;
    cyc;
    cyc;
    rdy_in = 1'b1;
    wait_mem(lat, res);
    checks++; if (res !== 32'h12345678) begin failures++; $display("FAIL pause_data got=%h want=12345678", res); end
    checks++; if (lat < 0 || lat + 3 < 8 || lat + 3 > 16) begin failures++; $display("FAIL pause_latency got=%0d want=8..16", lat + 3); end
    cyc;
    req(1'b1, 3'b000, 32'h500, 32'h0000_00A5);
    rdy_in = 1'b0;
    #1;
    checks++; if (bus.ram_wr !== 1'b0) begin failures++; $display("FAIL pause_wr got=%b want=0", bus.ram_wr); end
    cyc;
    rdy_in = 1'b1;
    #1;
    checks++; if (bus.ram_wr !== 1'b1 || bus.ram_dout !== 8'hA5) begin failures++; $display("FAIL resume_wr got=%b/%h want=1/a5", bus.ram_wr, bus.ram_dout); end
    wait_mem(lat, res);
    checks++; if (lat !== 2 || res !== 32'h0) begin failures++; $display("FAIL pause_st got=%0d/%h want=2/0", lat, res); end
    cyc;
  endtask
  task automatic test_reset_mid_write;
    logic seen;
    req(1'b1, 3'b010, 32'h500, 32'h1122_3344);
    cyc;
    checks++; if (bus.ram_wr !== 1'b1) begin failures++; $display("FAIL rstw_active got=%b want=1", bus.ram_wr); end
    #1;
    rst_in = 1'b1;
    #1;
    checks++; if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'h0 || bus.ram_dout !== 8'h0) begin failures++; $display("FAIL rstw_async got=%b/%h/%h want=0/0/0", bus.ram_wr, bus.ram_a, bus.ram_dout); end
    checks++; if (bus.mem_ready !== 1'b0 || bus.mem_result !== 32'h0) begin failures++; $display("FAIL rstw_outs got=%b/%h want=0/0", bus.mem_ready, bus.mem_result); end
    cyc;
    cyc;
    rst_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin seen |= bus.mem_ready | bus.ram_wr; cyc; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstw_quiet got=%b want=0", seen); end
  endtask
  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_wr = 1'b0; bus.mem_len = 3'b010; bus.mem_addr = '0; bus.mem_value = '0;
    bus.if_valid = 1'b0; bus.if_addr = '0; bus.io_buffer_full = 1'b0;
    for (int i = 0; i < 4096; i++) ram_m[i] = 8'h00;
    ram_m[12'h100] = 8'h78; ram_m[12'h101] = 8'h56; ram_m[12'h102] = 8'h34; ram_m[12'h103] = 8'h12; ram_m[12'h104] = 8'h9A;
    ram_m[12'h200] = 8'h80; ram_m[12'h210] = 8'h01; ram_m[12'h211] = 8'h80;
    ram_m[12'h400] = 8'hEF; ram_m[12'h401] = 8'hBE; ram_m[12'h402] = 8'hAD; ram_m[12'h403] = 8'hDE;
    ram_m[12'hFFE] = 8'h11; ram_m[12'hFFF] = 8'h22; ram_m[12'h000] = 8'h33; ram_m[12'h001] = 8'h44;
    test_reset;
    test_lw;
    test_loads;
    test_store_io;
    test_priority;
    test_rob_clear_load;
    test_rob_clear_store;
    test_rdy_pause;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
